// File: rtl/nios_timer_pkg.sv
// Shared definitions for the Nios interval timer: register map, control bits
// and the tick scheduler's FSM encoding.
package nios_timer_pkg;

    localparam logic [2:0] REG_STATUS  = 3'd0;
    localparam logic [2:0] REG_CONTROL = 3'd1;
    localparam logic [2:0] REG_PERIODL = 3'd2;
    localparam logic [2:0] REG_PERIODH = 3'd3;
    localparam logic [2:0] REG_SNAPL   = 3'd4;
    localparam logic [2:0] REG_SNAPH   = 3'd5;

    localparam int CTRL_ITO   = 0;
    localparam int CTRL_CONT  = 1;
    localparam int CTRL_START = 2;
    localparam int CTRL_STOP  = 3;

    // Continuous mode, interrupt on timeout, started.
    localparam logic [15:0] CTRL_RUN_WORD =
        16'((1 << CTRL_START) | (1 << CTRL_CONT) | (1 << CTRL_ITO));

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CFG_PL,
        ST_CFG_PH,
        ST_CFG_CTRL,
        ST_ACK,
        ST_GUARD,
        ST_SCAN
    } sched_state_t;

    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/nios_sched_channel.sv
// One virtual timer channel: a reload counter that is advanced once per
// scheduler scan and fires when it runs out.
module nios_sched_channel
    import nios_timer_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr,
    input  logic [CNT_W-1:0] reload_in,
    input  logic             en_in,
    input  logic             scan,
    output logic             fire
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] reload;
    logic             en;
    logic [CNT_W-1:0] wr_start;
    logic [CNT_W-1:0] scan_start;

    // A reload of zero behaves like one so the channel fires every tick.
    assign wr_start   = (reload_in == '0) ? CNT_W'(1) : reload_in;
    assign scan_start = (reload == '0) ? CNT_W'(1) : reload;

    assign fire = scan && en && !wr && (cnt <= CNT_W'(1));

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt    <= '0;
            reload <= '0;
            en     <= 1'b0;
        end else if (wr) begin
            reload <= reload_in;
            en     <= en_in;
            cnt    <= wr_start;
        end else if (scan && en) begin
            if (cnt <= CNT_W'(1)) begin
                cnt <= scan_start;
            end else begin
                cnt <= cnt - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/nios_timer_tick_scheduler.sv
// Sole Avalon-MM master of the Nios interval timer: programs and starts it,
// acknowledges each timeout and fans the tick out to NUM_CH channels.
module nios_timer_tick_scheduler
    import nios_timer_pkg::*;
#(
    parameter int          NUM_CH         = 4,
    parameter int          CNT_W          = 16,
    parameter bit          AUTO_START     = 1'b1,
    parameter logic [31:0] DEFAULT_PERIOD = 32'hC34F,
    localparam int         SEL_W          = sel_width(NUM_CH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_start,
    input  logic [31:0]       cfg_period,
    input  logic              ch_wr,
    input  logic [SEL_W-1:0]  ch_sel,
    input  logic [CNT_W-1:0]  ch_reload,
    input  logic              ch_en_in,
    output logic [NUM_CH-1:0] ch_fire,
    output logic              tick,
    output logic              running,
    output logic [2:0]        tmr_address,
    output logic              tmr_chipselect,
    output logic              tmr_write_n,
    output logic [15:0]       tmr_writedata,
    input  logic              tmr_irq
);

    sched_state_t     state;
    logic [SEL_W-1:0] idx;
    logic             pend;
    logic [31:0]      pend_period;
    logic [15:0]      period_hi;

    // Bus outputs are registered together with the state, so each write is
    // visible during the cycle its state occupies. The high half is latched
    // on entry so a cfg_start mid-sequence cannot tear the period.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= ST_IDLE;
            idx            <= '0;
            pend           <= AUTO_START;
            pend_period    <= DEFAULT_PERIOD;
            period_hi      <= '0;
            running        <= 1'b0;
            tick           <= 1'b0;
            tmr_chipselect <= 1'b0;
            tmr_write_n    <= 1'b1;
            tmr_address    <= '0;
            tmr_writedata  <= '0;
        end else begin
            tick           <= 1'b0;
            tmr_chipselect <= 1'b0;
            tmr_write_n    <= 1'b1;
            tmr_address    <= '0;
            tmr_writedata  <= '0;
            case (state)
                ST_IDLE: begin
                    if (pend) begin
                        state          <= ST_CFG_PL;
                        pend           <= 1'b0;
                        period_hi      <= pend_period[31:16];
                        running        <= 1'b0;
                        tmr_chipselect <= 1'b1;
                        tmr_write_n    <= 1'b0;
                        tmr_address    <= REG_PERIODL;
                        tmr_writedata  <= pend_period[15:0];
                    end else if (tmr_irq && running) begin
                        state          <= ST_ACK;
                        tick           <= 1'b1;
                        tmr_chipselect <= 1'b1;
                        tmr_write_n    <= 1'b0;
                        tmr_address    <= REG_STATUS;
                        tmr_writedata  <= '0;
                    end
                end
                ST_CFG_PL: begin
                    state          <= ST_CFG_PH;
                    tmr_chipselect <= 1'b1;
                    tmr_write_n    <= 1'b0;
                    tmr_address    <= REG_PERIODH;
                    tmr_writedata  <= period_hi;
                end
                ST_CFG_PH: begin
                    state          <= ST_CFG_CTRL;
                    tmr_chipselect <= 1'b1;
                    tmr_write_n    <= 1'b0;
                    tmr_address    <= REG_CONTROL;
                    tmr_writedata  <= CTRL_RUN_WORD;
                end
                ST_CFG_CTRL: begin
                    state   <= ST_IDLE;
                    running <= 1'b1;
                end
                ST_ACK: begin
                    state <= ST_GUARD;
                end
                ST_GUARD: begin
                    state <= ST_SCAN;
                    idx   <= '0;
                end
                ST_SCAN: begin
                    if (idx == SEL_W'(NUM_CH - 1)) begin
                        state <= ST_IDLE;
                    end else begin
                        idx <= idx + SEL_W'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
            // A new request always wins over the one just consumed above.
            if (cfg_start) begin
                pend        <= 1'b1;
                pend_period <= cfg_period;
            end
        end
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        nios_sched_channel #(
            .CNT_W (CNT_W)
        ) u_ch (
            .clk       (clk),
            .reset     (reset),
            .wr        (ch_wr && (ch_sel == SEL_W'(k))),
            .reload_in (ch_reload),
            .en_in     (ch_en_in),
            .scan      ((state == ST_SCAN) && (idx == SEL_W'(k))),
            .fire      (ch_fire[k])
        );
    end

endmodule

// File: tb/tb_nios_timer_tick_scheduler.sv
// Self-checking bench: a timeline model of bus writes, ticks and channel scans
// is compared every cycle, plus hand-computed checks of key scenarios.
module tb_nios_timer_tick_scheduler;

    localparam int          NUM_CH     = 4;
    localparam int          CNT_W      = 16;
    localparam int          SEL_W      = 2;
    localparam logic [31:0] DEF_PERIOD = 32'hC34F;

    logic              clk;
    logic              reset;
    logic              cfg_start;
    logic [31:0]       cfg_period;
    logic              ch_wr;
    logic [SEL_W-1:0]  ch_sel;
    logic [CNT_W-1:0]  ch_reload;
    logic              ch_en_in;
    logic [NUM_CH-1:0] ch_fire;
    logic              tick;
    logic              running;
    logic [2:0]        tmr_address;
    logic              tmr_chipselect;
    logic              tmr_write_n;
    logic [15:0]       tmr_writedata;
    logic              tmr_irq;

    nios_timer_tick_scheduler #(
        .NUM_CH         (NUM_CH),
        .CNT_W          (CNT_W),
        .AUTO_START     (1'b1),
        .DEFAULT_PERIOD (DEF_PERIOD)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .cfg_start      (cfg_start),
        .cfg_period     (cfg_period),
        .ch_wr          (ch_wr),
        .ch_sel         (ch_sel),
        .ch_reload      (ch_reload),
        .ch_en_in       (ch_en_in),
        .ch_fire        (ch_fire),
        .tick           (tick),
        .running        (running),
        .tmr_address    (tmr_address),
        .tmr_chipselect (tmr_chipselect),
        .tmr_write_n    (tmr_write_n),
        .tmr_writedata  (tmr_writedata),
        .tmr_irq        (tmr_irq)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    initial begin
        forever begin
            @(posedge clk);
            cyc <= cyc + 1;
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [CNT_W-1:0] atLeastOne(input logic [CNT_W-1:0] v);
        return (v == '0) ? CNT_W'(1) : v;
    endfunction

    // Timeline model: what the scheduler does in each numbered cycle.
    bit               model_on = 1'b0;
    int               idle_from;
    bit               pend_m;
    logic [31:0]      pend_period_m;
    bit               run_m = 1'b0;
    logic [CNT_W-1:0] m_cnt    [NUM_CH];
    logic [CNT_W-1:0] m_reload [NUM_CH];
    bit               m_en     [NUM_CH];
    int               exp_addr [int];
    int               exp_data [int];
    bit               exp_tick [int];
    int               scan_at  [int];
    bit               run_chg  [int];
    int               mc;
    int               mk;
    logic [NUM_CH-1:0] exp_fire;
    logic [31:0]      exp_bus;

    initial begin
        forever begin
            @(negedge clk);
            mc = cyc;
            if (model_on) begin
                if (run_chg.exists(mc)) run_m = run_chg[mc];
                exp_fire = '0;
                if (scan_at.exists(mc)) begin
                    mk = scan_at[mc];
                    if (!(ch_wr && (int'(ch_sel) == mk)) && m_en[mk]) begin
                        if (m_cnt[mk] <= 1) begin
                            exp_fire[mk] = 1'b1;
                            m_cnt[mk]    = atLeastOne(m_reload[mk]);
                        end else begin
                            m_cnt[mk] = m_cnt[mk] - 1;
                        end
                    end
                end
                if (exp_addr.exists(mc))
                    exp_bus = {11'b0, 1'b1, 1'b0, 3'(exp_addr[mc]), 16'(exp_data[mc])};
                else
                    exp_bus = {11'b0, 1'b0, 1'b1, 3'b0, 16'b0};
                checkOutput("ch_fire", 32'(ch_fire), 32'(exp_fire));
                checkOutput("tick", 32'(tick), 32'(exp_tick.exists(mc)));
                checkOutput("running", 32'(running), 32'(run_m));
                checkOutput("bus", {11'b0, tmr_chipselect, tmr_write_n, tmr_address, tmr_writedata}, exp_bus);
            end
            if (reset) begin
                model_on      = 1'b1;
                exp_addr.delete();
                exp_data.delete();
                exp_tick.delete();
                scan_at.delete();
                run_chg.delete();
                pend_m        = 1'b1;
                pend_period_m = DEF_PERIOD;
                idle_from     = mc + 1;
                run_chg[mc+1] = 1'b0;
                for (int k = 0; k < NUM_CH; k++) begin
                    m_cnt[k]    = '0;
                    m_reload[k] = '0;
                    m_en[k]     = 1'b0;
                end
            end else if (model_on) begin
                if (mc >= idle_from) begin
                    if (pend_m) begin
                        pend_m        = 1'b0;
                        exp_addr[mc+1] = 2; exp_data[mc+1] = int'(pend_period_m[15:0]);
                        exp_addr[mc+2] = 3; exp_data[mc+2] = int'(pend_period_m[31:16]);
                        exp_addr[mc+3] = 1; exp_data[mc+3] = 7;
                        run_chg[mc+1] = 1'b0;
                        run_chg[mc+4] = 1'b1;
                        idle_from     = mc + 4;
                    end else if (tmr_irq && run_m) begin
                        exp_addr[mc+1] = 0; exp_data[mc+1] = 0;
                        exp_tick[mc+1] = 1'b1;
                        for (int k = 0; k < NUM_CH; k++) scan_at[mc+3+k] = k;
                        idle_from = mc + 3 + NUM_CH;
                    end
                end
                if (cfg_start) begin
                    pend_m        = 1'b1;
                    pend_period_m = cfg_period;
                end
                if (ch_wr) begin
                    m_reload[ch_sel] = ch_reload;
                    m_en[ch_sel]     = ch_en_in;
                    m_cnt[ch_sel]    = atLeastOne(ch_reload);
                end
            end
        end
    end

    // Observed fire counts and bus write log for the scenario checks.
    int          fire_cnt [NUM_CH];
    logic [18:0] bus_log  [$];
    initial begin
        for (int k = 0; k < NUM_CH; k++) fire_cnt[k] = 0;
        forever begin
            @(negedge clk);
            for (int k = 0; k < NUM_CH; k++) if (ch_fire[k] === 1'b1) fire_cnt[k]++;
            if (tmr_chipselect === 1'b1 && tmr_write_n === 1'b0)
                bus_log.push_back({tmr_address, tmr_writedata});
        end
    end

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives one cycle of inputs starting now (just after a rising edge).
    task automatic applyStimulus(input logic wr, input logic [SEL_W-1:0] sel,
                                 input logic [CNT_W-1:0] rl, input logic en,
                                 input logic start, input logic [31:0] per);
        ch_wr = wr; ch_sel = sel; ch_reload = rl; ch_en_in = en;
        cfg_start = start; cfg_period = per;
        @(posedge clk);
        #1;
        ch_wr = 1'b0; ch_sel = '0; ch_reload = '0; ch_en_in = 1'b0;
        cfg_start = 1'b0; cfg_period = '0;
    endtask

    // Raises the timer interrupt and drops it once the ACK write appears.
    task automatic fireTimer();
        int raise_cyc;
        int lat;
        bit got;
        tmr_irq   = 1'b1;
        raise_cyc = cyc;
        got       = 1'b0;
        lat       = 99;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (tmr_chipselect && !tmr_write_n && tmr_address == 3'd0) begin
                got = 1'b1;
                lat = cyc - raise_cyc;
            end
        end
        checkOutput("ack_latency", 32'(lat), 32'd1);
        @(posedge clk);
        #1;
        tmr_irq = 1'b0;
    endtask

    logic [2:0]  lit_addr [3];
    logic [15:0] lit_data [3];
    int          base0, base1, base2, lbase;

    initial begin
        reset = 1'b1; cfg_start = 1'b0; cfg_period = '0; ch_wr = 1'b0;
        ch_sel = '0; ch_reload = '0; ch_en_in = 1'b0; tmr_irq = 1'b0;
        lit_addr = '{3'd2, 3'd3, 3'd1};
        lit_data = '{16'hC34F, 16'h0000, 16'h0007};
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        @(negedge clk);
        checkOutput("reset_cs", 32'(tmr_chipselect), 32'd0);
        checkOutput("reset_write_n", 32'(tmr_write_n), 32'd1);
        checkOutput("reset_running", 32'(running), 32'd0);
        checkOutput("reset_fire", 32'(ch_fire), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            checkOutput("auto_cfg_cs", 32'(tmr_chipselect), 32'd1);
            checkOutput("auto_cfg_addr", 32'(tmr_address), 32'(lit_addr[i]));
            checkOutput("auto_cfg_data", 32'(tmr_writedata), 32'(lit_data[i]));
        end
        @(posedge clk);
        @(negedge clk);
        checkOutput("running_cycle4", 32'(running), 32'd1);
        @(posedge clk);
        #1;

        applyStimulus(1'b1, 2'd0, 16'd3, 1'b1, 1'b0, 32'd0);
        applyStimulus(1'b1, 2'd1, 16'd0, 1'b1, 1'b0, 32'd0);
        applyStimulus(1'b1, 2'd2, 16'd1, 1'b1, 1'b0, 32'd0);
        base0 = fire_cnt[0];
        base1 = fire_cnt[1];
        repeat (9) begin
            fireTimer();
            waitCycles(6);
        end
        checkOutput("ch0_fires_in_9_ticks", 32'(fire_cnt[0] - base0), 32'd3);
        checkOutput("ch1_fires_in_9_ticks", 32'(fire_cnt[1] - base1), 32'd9);

        fireTimer();
        waitCycles(1);
        lbase = bus_log.size();
        applyStimulus(1'b0, 2'd0, 16'd0, 1'b0, 1'b1, 32'h0001_86A0);
        waitCycles(12);
        checkOutput("midscan_cfg_writes", 32'(bus_log.size() - lbase), 32'd3);
        if (bus_log.size() - lbase >= 3) begin
            checkOutput("midscan_cfg_pl", 32'(bus_log[lbase]),   32'({3'd2, 16'h86A0}));
            checkOutput("midscan_cfg_ph", 32'(bus_log[lbase+1]), 32'({3'd3, 16'h0001}));
            checkOutput("midscan_cfg_ctrl", 32'(bus_log[lbase+2]), 32'({3'd1, 16'h0007}));
        end
        checkOutput("running_after_recfg", 32'(running), 32'd1);

        fireTimer();
        waitCycles(3);
        base2 = fire_cnt[2];
        applyStimulus(1'b1, 2'd2, 16'd5, 1'b1, 1'b0, 32'd0);
        waitCycles(3);
        checkOutput("ch2_write_wins", 32'(fire_cnt[2] - base2), 32'd0);
        repeat (4) begin
            fireTimer();
            waitCycles(6);
        end
        checkOutput("ch2_quiet_4_ticks", 32'(fire_cnt[2] - base2), 32'd0);
        fireTimer();
        waitCycles(6);
        checkOutput("ch2_fires_5th_tick", 32'(fire_cnt[2] - base2), 32'd1);

        applyStimulus(1'b0, 2'd0, 16'd0, 1'b0, 1'b1, 32'h0000_0100);
        waitCycles(2);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checkOutput("midreset_cs", 32'(tmr_chipselect), 32'd0);
        checkOutput("midreset_write_n", 32'(tmr_write_n), 32'd1);
        checkOutput("midreset_addr", 32'(tmr_address), 32'd0);
        checkOutput("midreset_running", 32'(running), 32'd0);
        checkOutput("midreset_fire", 32'(ch_fire), 32'd0);
        @(posedge clk);
        #1;
        waitCycles(5);
        checkOutput("running_after_reset_restart", 32'(running), 32'd1);
        fireTimer();
        waitCycles(8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
